// File: rtl/pc_gen_pkg.sv
// Shared encodings for the fetch-stage PC generator: next-PC select codes,
// branch condition codes and default vector addresses.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        NpcSeq    = 2'b00,
        NpcBranch = 2'b01,
        NpcJump   = 2'b10,
        NpcJr     = 2'b11
    } npc_sel_e;

    typedef enum logic [2:0] {
        BrEq  = 3'b000,
        BrNe  = 3'b001,
        BrLez = 3'b010,
        BrGtz = 3'b011,
        BrLtz = 3'b100,
        BrGez = 3'b101
    } br_cond_e;

    localparam logic [31:0] DefaultResetPc = 32'h0000_3000;
    localparam logic [31:0] DefaultExcPc   = 32'h0000_4180;
    localparam int unsigned DefaultImemBytes = 4096;

endpackage

// File: rtl/pc_gen_if.sv
// Control-transfer bus between the decode stage and the PC generator.
// The master drives D-stage decisions; the slave (pc_gen) returns fetch state.
interface pc_gen_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic [1:0]       npc_sel;
    logic [2:0]       br_cond;
    logic [WIDTH-1:0] d_pc_plus4;
    logic [25:0]      i_addr;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] r_addr;
    logic             exc_req;
    logic             eret_req;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] f_pc;
    logic [WIDTH-1:0] d_pc_plus8;
    logic             br_taken;
    logic             f_adel;
    logic [15:0]      redirect_cnt;

    modport master (
        output stall, npc_sel, br_cond, d_pc_plus4, i_addr, rs_val, rt_val, r_addr,
        output exc_req, eret_req, epc,
        input  f_pc, d_pc_plus8, br_taken, f_adel, redirect_cnt
    );

    modport slave (
        input  stall, npc_sel, br_cond, d_pc_plus4, i_addr, rs_val, rt_val, r_addr,
        input  exc_req, eret_req, epc,
        output f_pc, d_pc_plus8, br_taken, f_adel, redirect_cnt
    );
endinterface

// File: rtl/pc_gen_br_cmp.sv
// Branch condition evaluator for the beq/bne/blez/bgtz/bltz/bgez family.
// Purely combinational; unknown condition codes are never taken.
module pc_gen_br_cmp import pc_gen_pkg::*; #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rs_val_i,
    input  logic [WIDTH-1:0] rt_val_i,
    input  logic [2:0]       br_cond_i,
    output logic             cond_true_o
);

    logic rs_neg;
    logic rs_zero;
    logic rs_eq_rt;

    // Signed compares against zero reduce to sign-bit and zero tests.
    assign rs_neg   = rs_val_i[WIDTH-1];
    assign rs_zero  = (rs_val_i == '0);
    assign rs_eq_rt = (rs_val_i == rt_val_i);

    always_comb begin
        cond_true_o = 1'b0;
        case (br_cond_i)
            BrEq:    cond_true_o = rs_eq_rt;
            BrNe:    cond_true_o = !rs_eq_rt;
            BrLez:   cond_true_o = rs_neg || rs_zero;
            BrGtz:   cond_true_o = !rs_neg && !rs_zero;
            BrLtz:   cond_true_o = rs_neg;
            BrGez:   cond_true_o = !rs_neg;
            default: cond_true_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC register with branch-delay-slot next-PC selection, stall hold,
// exception/eret redirect, fetch address-error flag and a redirect counter.
module pc_gen import pc_gen_pkg::*; #(
    parameter int unsigned     WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DefaultResetPc),
    parameter logic [WIDTH-1:0] EXC_PC    = WIDTH'(DefaultExcPc),
    parameter int unsigned     IMEM_BYTES = DefaultImemBytes
) (
    input logic     clk,
    input logic     reset,
    pc_gen_if.slave bus
);

    localparam logic [WIDTH-1:0] ImemEnd = RESET_PC + WIDTH'(IMEM_BYTES);

    logic [WIDTH-1:0] f_pc_q, f_pc_d;
    logic             f_adel_q, f_adel_d;
    logic [15:0]      redirect_cnt_q, redirect_cnt_d;

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] npc;
    logic [15:0]      imm16;
    logic             cond_true;
    logic             redirect;

    pc_gen_br_cmp #(
        .WIDTH (WIDTH)
    ) u_br_cmp (
        .rs_val_i    (bus.rs_val),
        .rt_val_i    (bus.rt_val),
        .br_cond_i   (bus.br_cond),
        .cond_true_o (cond_true)
    );

    assign imm16       = bus.i_addr[15:0];
    assign seq_pc      = f_pc_q + WIDTH'(4);
    assign br_target   = bus.d_pc_plus4 + {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
    assign jump_target = {bus.d_pc_plus4[WIDTH-1:28], bus.i_addr, 2'b00};

    // D-stage selection; the delay-slot instruction is already in F, so no squash.
    always_comb begin
        npc      = seq_pc;
        redirect = 1'b0;
        unique case (bus.npc_sel)
            NpcSeq: begin
                npc = seq_pc;
            end
            NpcBranch: begin
                if (cond_true) begin
                    npc      = br_target;
                    redirect = 1'b1;
                end
            end
            NpcJump: begin
                npc      = jump_target;
                redirect = 1'b1;
            end
            NpcJr: begin
                npc      = bus.r_addr;
                redirect = 1'b1;
            end
            default: begin
                npc = seq_pc;
            end
        endcase
    end

    always_comb begin
        f_pc_d         = f_pc_q;
        redirect_cnt_d = redirect_cnt_q;
        if (bus.exc_req) begin
            f_pc_d = EXC_PC;
        end else if (bus.eret_req) begin
            f_pc_d = bus.epc;
        end else if (!bus.stall) begin
            f_pc_d = npc;
            if (redirect && (redirect_cnt_q != 16'hFFFF)) begin
                redirect_cnt_d = redirect_cnt_q + 16'd1;
            end
        end
    end

    // Flag is computed from the value being loaded so it always tracks f_pc.
    assign f_adel_d = (f_pc_d[1:0] != 2'b00) || (f_pc_d < RESET_PC) || (f_pc_d >= ImemEnd);

    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_q         <= RESET_PC;
            f_adel_q       <= 1'b0;
            redirect_cnt_q <= '0;
        end else begin
            f_pc_q         <= f_pc_d;
            f_adel_q       <= f_adel_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign bus.f_pc         = f_pc_q;
    assign bus.f_adel       = f_adel_q;
    assign bus.redirect_cnt = redirect_cnt_q;
    assign bus.d_pc_plus8   = bus.d_pc_plus4 + WIDTH'(4);
    assign bus.br_taken     = (bus.npc_sel == NpcBranch) && cond_true;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Fetch-stage program counter generator for the pipelined MIPS core.
- Holds the architectural F-stage PC register and computes the next PC from the D-stage control-transfer instruction, with branch-delay-slot semantics.
- Branch comparison is done internally for the full branch family (beq/bne/blez/bgtz/bltz/bgez).
- Adds stall hold, exception-vector redirect, eret return, and a registered fetch-address-error flag.

Parameters:
- WIDTH, 32, address/data width; must be 32 or greater.
- RESET_PC, 32'h0000_3000, PC value loaded by reset.
- EXC_PC, 32'h0000_4180, exception handler entry address.
- IMEM_BYTES, 4096, instruction memory size; legal fetch range is [RESET_PC, RESET_PC+IMEM_BYTES).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold F_PC; ignore D-stage redirect this cycle
- npc_sel  in  2  00 SEQ, 01 BRANCH, 10 JUMP (j/jal), 11 JR (jr/jalr)
- br_cond  in  3  000 EQ, 001 NE, 010 LEZ, 011 GTZ, 100 LTZ, 101 GEZ, others never taken
- d_pc_plus4  in  WIDTH  PC+4 of the D-stage instruction
- i_addr  in  26  instr[25:0] of the D-stage instruction (imm16 = i_addr[15:0])
- rs_val  in  WIDTH  forwarded rs value
- rt_val  in  WIDTH  forwarded rt value
- r_addr  in  WIDTH  jr target (forwarded rs)
- exc_req  in  1  exception commit: redirect to EXC_PC
- eret_req  in  1  eret commit: redirect to epc
- epc  in  WIDTH  return address from CP0
- f_pc  out  WIDTH  current fetch PC (register)
- d_pc_plus8  out  WIDTH  link address = d_pc_plus4+4 (combinational)
- br_taken  out  1  combinational: npc_sel==BRANCH and condition true
- f_adel  out  1  registered fetch address error
- redirect_cnt  out  16  count of taken control transfers, saturating at 16'hFFFF

Behaviour:
- Reset values: f_pc=RESET_PC, f_adel=0, redirect_cnt=0.
- Next-PC candidates:
  - seq = f_pc+4
  - branch target = d_pc_plus4 + (sext(imm16)<<2)
  - jump = {d_pc_plus4[31:28], i_addr, 2'b00}
  - jr = r_addr
- Conditions use signed WIDTH compares:
  - EQ: rs==rt; NE: rs!=rt
  - LEZ: rs<=0; GTZ: rs>0; LTZ: rs<0; GEZ: rs>=0
- All arithmetic is modulo 2^WIDTH; wrap-around is silent.
- Per-cycle update priority on the rising edge, highest first:
  1. reset: load reset values.
  2. exc_req: f_pc<=EXC_PC, regardless of stall or eret_req.
  3. eret_req: f_pc<=epc, regardless of stall.
  4. stall: f_pc holds; redirect_cnt holds.
  5. npc_sel: SEQ -> seq; BRANCH -> target if taken, else seq; JUMP -> jump; JR -> jr.
- Delay slot: the instruction at D's PC+4 is already in F when D redirects, so one slot always executes. The block performs no squash.
- redirect_cnt increments by 1 on each non-stalled cycle that takes BRANCH(taken), JUMP or JR. exc_req and eret_req do not count.
- f_adel <= (next f_pc[1:0]!=0) or (next f_pc outside the legal range). It is evaluated on the same edge that loads f_pc, so it always describes the current f_pc.
- Reset mid-stall or mid-exception: reset wins; no pending state survives.
- Latency: a redirect is visible on f_pc one cycle after the D-stage decision.

Decomposition:
- Shared package: NPC_SEQ/BRANCH/JUMP/JR codes, BR_EQ..BR_GEZ codes, default RESET_PC and EXC_PC constants.
- One sub-module: br_cmp. It is combinational: rs_val, rt_val, br_cond -> cond_true.

Test Plan:
- Reset: reset=1 for 2 cycles -> f_pc=32'h3000, f_adel=0, redirect_cnt=0; then 3 SEQ cycles -> f_pc=3004, 3008, 300C.
- Branch: BRANCH+EQ with d_pc_plus4=32'h3008, imm16=16'hFFFE, rs=rt=5 -> br_taken=1, next f_pc=32'h3000, redirect_cnt=1. Same stimulus with rt=6 -> f_pc=previous+4, cnt unchanged.
- Signed conditions: GTZ with rs=32'h8000_0000 -> not taken; GEZ with rs=0 -> taken; LTZ with rs=32'hFFFF_FFFF -> taken.
- Jump/JR/link: JUMP with d_pc_plus4=32'h3010, i_addr=26'h0000C40 -> f_pc=32'h3100, d_pc_plus8=32'h3014. JR with r_addr=32'h3204 -> f_pc=32'h3204.
- Stall and exceptions: stall=1 with JUMP -> f_pc holds, cnt holds. stall=1 with exc_req=1 -> f_pc=32'h4180. exc_req and eret_req together -> 32'h4180. eret alone with epc=32'h3020 -> f_pc=32'h3020.
- Address error: JR with r_addr=32'h3002 -> f_adel=1 next cycle. JR with r_addr=32'h4000 (IMEM_BYTES=4096) -> f_adel=1. JR with r_addr=32'h3FFC -> f_adel=0.
